nic_input_arbiter: RTL and testbench

Packet-granular round-robin arbiter that merges NUM_QUEUES input queues (MAC and CPU DMA ports) into the single stream consumed by the NIC output port lookup stage. Each input has its own small fall-through FIFO. A grant is held for one whole packet: module headers, payload, and the end-of-packet word. Packets from different queues are never interleaved.

---
 rtl/nic_input_arbiter_pkg.sv | 12 +
 rtl/fallthrough_small_fifo.sv | 50 +++++
 rtl/nic_input_arbiter_rr_pick.sv | 29 ++
 rtl/nic_input_arbiter.sv | 117 +++++++++++
 tb/tb_nic_input_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nic_input_arbiter_pkg.sv
// Shared definitions for the NIC input arbiter: FSM encodings and per-queue FIFO depth.
package nic_input_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDRS    = 2'd1,
    PAYLOAD = 2'd2
  } arb_state_t;

  localparam int MAX_DEPTH_BITS = 2;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small fall-through FIFO: the head word is visible on dout whenever the FIFO is not empty.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [MAX_DEPTH_BITS:0]   count;
  logic                      do_wr, do_rd;

  assign do_wr       = wr_en && (count != (MAX_DEPTH_BITS+1)'(DEPTH));
  assign do_rd       = rd_en && (count != '0);
  assign empty       = (count == '0);
  // Deasserts ready one slot early so a writer reacting to in_rdy never overflows.
  assign nearly_full = (count >= (MAX_DEPTH_BITS+1)'(DEPTH-1));
  assign dout        = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/nic_input_arbiter_rr_pick.sv
// Combinational round-robin search: first non-empty queue at or after rr_ptr, wrapping at NUM_QUEUES.
module rr_pick #(
  parameter int NUM_QUEUES = 8,
  parameter int QSEL_BITS  = $clog2(NUM_QUEUES)
) (
  input  logic [NUM_QUEUES-1:0] empty,
  input  logic [QSEL_BITS-1:0]  rr_ptr,
  output logic                  found,
  output logic [QSEL_BITS-1:0]  sel
);

  logic [QSEL_BITS:0] idx;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int off = 0; off < NUM_QUEUES; off++) begin
      // Explicit wrap keeps non-power-of-two queue counts from indexing past the last queue.
      idx = {1'b0, rr_ptr} + (QSEL_BITS+1)'(off);
      if (idx >= (QSEL_BITS+1)'(NUM_QUEUES)) idx = idx - (QSEL_BITS+1)'(NUM_QUEUES);
      if (!found && !empty[idx[QSEL_BITS-1:0]]) begin
        found = 1'b1;
        sel   = idx[QSEL_BITS-1:0];
      end
    end
  end

endmodule

// File: rtl/nic_input_arbiter.sv
// Packet-granular round-robin merge of NUM_QUEUES input queues into one registered output stream.
module nic_input_arbiter
  import nic_input_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_QUEUES = 8,
  parameter int QSEL_BITS  = $clog2(NUM_QUEUES)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
  input  logic [NUM_QUEUES-1:0]            in_wr,
  output logic [NUM_QUEUES-1:0]            in_rdy,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
  output logic [QSEL_BITS-1:0]             cur_queue
);

  localparam int FIFO_W = CTRL_WIDTH + DATA_WIDTH;

  arb_state_t             state, state_nxt;
  logic [QSEL_BITS-1:0]   rr_ptr, rr_ptr_nxt, pick_sel;
  logic                   pick_found, grant, rd_en;
  logic [FIFO_W-1:0]      head [NUM_QUEUES];
  logic [FIFO_W-1:0]      head_word;
  logic [CTRL_WIDTH-1:0]  head_ctrl;
  logic [DATA_WIDTH-1:0]  head_data;
  logic [NUM_QUEUES-1:0]  empty, nearly_full, fifo_rd;

  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_q
    // Only the granted FIFO ever sees a read strobe.
    assign fifo_rd[i] = rd_en && (cur_queue == QSEL_BITS'(i));

    fallthrough_small_fifo #(
      .WIDTH          (FIFO_W),
      .MAX_DEPTH_BITS (MAX_DEPTH_BITS)
    ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .din         ({in_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH], in_data[i*DATA_WIDTH +: DATA_WIDTH]}),
      .wr_en       (in_wr[i]),
      .rd_en       (fifo_rd[i]),
      .dout        (head[i]),
      .nearly_full (nearly_full[i]),
      .empty       (empty[i])
    );
  end

  assign in_rdy = ~nearly_full;

  rr_pick #(
    .NUM_QUEUES (NUM_QUEUES),
    .QSEL_BITS  (QSEL_BITS)
  ) u_pick (
    .empty  (empty),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .sel    (pick_sel)
  );

  assign head_word = head[cur_queue];
  assign head_ctrl = head_word[FIFO_W-1 -: CTRL_WIDTH];
  assign head_data = head_word[DATA_WIDTH-1:0];

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant      = 1'b0;
    rd_en      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant     = 1'b1;
          state_nxt = HDRS;
        end
      end
      HDRS: begin
        rd_en = out_rdy && !empty[cur_queue];
        if (rd_en && head_ctrl == '0) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        rd_en = out_rdy && !empty[cur_queue];
        // Non-zero ctrl after payload marks end of packet; hand priority to the next queue.
        if (rd_en && head_ctrl != '0) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = (cur_queue == QSEL_BITS'(NUM_QUEUES-1)) ? '0 : cur_queue + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_queue <= '0;
      out_wr    <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      out_wr <= rd_en;
      if (grant) cur_queue <= pick_sel;
      if (rd_en) begin
        out_data <= head_data;
        out_ctrl <= head_ctrl;
      end
    end
  end

endmodule

// File: tb/tb_nic_input_arbiter.sv
// Directed bench for nic_input_arbiter: per-cycle vector table plus multi-cycle packet scenarios.
module tb_nic_input_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [511:0] in_data = '0;
  logic [63:0]  in_ctrl = '0;
  logic [7:0]   in_wr = '0;
  logic [7:0]   in_rdy;
  logic [63:0]  out_data;
  logic [7:0]   out_ctrl;
  logic         out_wr;
  logic         out_rdy = 1'b1;
  logic [2:0]   cur_queue;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  nic_input_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .in_wr     (in_wr),
    .in_rdy    (in_rdy),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .out_wr    (out_wr),
    .out_rdy   (out_rdy),
    .cur_queue (cur_queue)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [7:0]  ctrl;
    logic [63:0] data;
    logic [2:0]  cq;
  } rec_t;

  typedef struct {
    logic        wr;
    logic [7:0]  ctrl;
    logic [63:0] data;
    logic        ordy;
    logic        e_wr;
    logic [7:0]  e_ctrl;
    logic [63:0] e_data;
    logic [2:0]  e_cq;
  } vec_t;

  rec_t        mon_q[$];
  logic [71:0] exp_q[$];
  logic [71:0] pend [8][$];
  vec_t        vt [10];

  always @(negedge clk) begin
    if (out_wr === 1'b1) mon_q.push_back('{cyc, out_ctrl, out_data, cur_queue});
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic logic [71:0] pkt_word(int q, int k, int n, int nh, logic [7:0] tag);
    logic [7:0] c;
    if (k < nh)          c = 8'h80 | 8'(k);
    else if (k == n - 1) c = 8'h01;
    else                 c = 8'h00;
    return {c, 8'(q), tag, 32'h0, 16'(k)};
  endfunction

  task automatic add_pkt(input int q, input int n, input int nh, input logic [7:0] tag);
    for (int k = 0; k < n; k++) begin
      pend[q].push_back(pkt_word(q, k, n, nh, tag));
      exp_q.push_back(pkt_word(q, k, n, nh, tag));
    end
  endtask

  task automatic cycle();
    logic        ordy_b;
    logic [71:0] w;
    in_wr = '0;
    for (int q = 0; q < 8; q++) begin
      if (pend[q].size() > 0 && in_rdy[q]) begin
        w = pend[q].pop_front();
        in_wr[q] = 1'b1;
        in_data[q*64 +: 64] = w[63:0];
        in_ctrl[q*8 +: 8]   = w[71:64];
      end
    end
    ordy_b = out_rdy;
    @(posedge clk); #1;
    in_wr = '0;
    chk("handshake", 64'(out_wr & ~ordy_b), 64'd0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_wr = '0;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int q = 0; q < 8; q++) pend[q].delete();
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic check_log(input string nm);
    chk({nm, "_count"}, 64'(mon_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      chk({nm, "_data"}, mon_q[i].data, exp_q[i][63:0]);
      chk({nm, "_ctrl"}, 64'(mon_q[i].ctrl), 64'(exp_q[i][71:64]));
      chk({nm, "_cq"}, 64'(mon_q[i].cq), 64'(exp_q[i][63:56]));
    end
  endtask

  initial begin
    // Single packet on queue 3: 2 headers, 4 payload, EOP ctrl 0x01.
    vt[0] = '{1'b1, 8'hFF, 64'h0300_0000_0000_0000, 1'b1, 1'b0, 8'h00, 64'h0,                   3'd0};
    vt[1] = '{1'b1, 8'hFE, 64'h0300_0000_0000_0001, 1'b1, 1'b0, 8'h00, 64'h0,                   3'd3};
    vt[2] = '{1'b1, 8'h00, 64'h0300_0000_0000_0002, 1'b1, 1'b1, 8'hFF, 64'h0300_0000_0000_0000, 3'd3};
    vt[3] = '{1'b1, 8'h00, 64'h0300_0000_0000_0003, 1'b1, 1'b1, 8'hFE, 64'h0300_0000_0000_0001, 3'd3};
    vt[4] = '{1'b1, 8'h00, 64'h0300_0000_0000_0004, 1'b1, 1'b1, 8'h00, 64'h0300_0000_0000_0002, 3'd3};
    vt[5] = '{1'b1, 8'h00, 64'h0300_0000_0000_0005, 1'b1, 1'b1, 8'h00, 64'h0300_0000_0000_0003, 3'd3};
    vt[6] = '{1'b1, 8'h01, 64'h0300_0000_0000_0006, 1'b1, 1'b1, 8'h00, 64'h0300_0000_0000_0004, 3'd3};
    vt[7] = '{1'b0, 8'h00, 64'h0,                   1'b1, 1'b1, 8'h00, 64'h0300_0000_0000_0005, 3'd3};
    vt[8] = '{1'b0, 8'h00, 64'h0,                   1'b1, 1'b1, 8'h01, 64'h0300_0000_0000_0006, 3'd3};
    vt[9] = '{1'b0, 8'h00, 64'h0,                   1'b1, 1'b0, 8'h01, 64'h0300_0000_0000_0006, 3'd3};

    do_reset();
    chk("rst_out_wr", 64'(out_wr), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_cur_queue", 64'(cur_queue), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'hFF);
    chk("rst_rr_ptr", 64'(dut.rr_ptr), 64'd0);

    for (int i = 0; i < 10; i++) begin
      in_wr = vt[i].wr ? 8'h08 : 8'h00;
      in_data[3*64 +: 64] = vt[i].data;
      in_ctrl[3*8 +: 8]   = vt[i].ctrl;
      out_rdy = vt[i].ordy;
      @(posedge clk); #1;
      in_wr = '0;
      chk($sformatf("t1_wr[%0d]", i), 64'(out_wr), 64'(vt[i].e_wr));
      chk($sformatf("t1_data[%0d]", i), out_data, vt[i].e_data);
      chk($sformatf("t1_ctrl[%0d]", i), 64'(out_ctrl), 64'(vt[i].e_ctrl));
      chk($sformatf("t1_cq[%0d]", i), 64'(cur_queue), 64'(vt[i].e_cq));
      chk($sformatf("t1_rdy[%0d]", i), 64'(in_rdy), 64'hFF);
    end
    chk("t1_rr_ptr", 64'(dut.rr_ptr), 64'd4);

    // Queues 0, 1, 7 each one packet; order 0,1,7 with one idle cycle between packets.
    do_reset();
    add_pkt(0, 3, 1, 8'hA0);
    add_pkt(1, 3, 1, 8'hA1);
    add_pkt(7, 3, 1, 8'hA7);
    run(25);
    check_log("t2");
    if (mon_q.size() == 9) begin
      for (int i = 1; i < 9; i++)
        chk($sformatf("t2_gap[%0d]", i), 64'(mon_q[i].cyc - mon_q[i-1].cyc), (i % 3 == 0) ? 64'd2 : 64'd1);
    end
    chk("t2_rr_ptr", 64'(dut.rr_ptr), 64'd0);

    // Queue 2 packet with queue 5 loaded concurrently: no interleave, 5 next.
    do_reset();
    add_pkt(2, 6, 2, 8'hB2);
    add_pkt(5, 5, 1, 8'hB5);
    run(30);
    check_log("t3");
    chk("t3_rr_ptr", 64'(dut.rr_ptr), 64'd6);

    // out_rdy pattern 1,0,0 repeating during a long packet.
    do_reset();
    add_pkt(0, 10, 1, 8'hC0);
    for (int c = 0; c < 45; c++) begin
      out_rdy = (c % 3 == 0);
      cycle();
    end
    out_rdy = 1'b1;
    run(3);
    check_log("t4");

    // Queue 4 fills to nearly_full under backpressure, then drains.
    do_reset();
    out_rdy = 1'b0;
    add_pkt(4, 5, 1, 8'hD4);
    run(6);
    chk("t5_rdy_blocked", 64'(in_rdy), 64'hEF);
    chk("t5_pending", 64'(pend[4].size()), 64'd2);
    chk("t5_no_output", 64'(mon_q.size()), 64'd0);
    chk("t5_cq", 64'(cur_queue), 64'd4);
    out_rdy = 1'b1;
    run(15);
    chk("t5_rdy_restored", 64'(in_rdy), 64'hFF);
    check_log("t5");

    // Reset in the middle of a queue-6 payload, then a fresh packet passes intact.
    do_reset();
    add_pkt(6, 10, 1, 8'hE6);
    begin
      int guard;
      guard = 0;
      while (mon_q.size() < 3 && guard < 40) begin
        cycle();
        guard++;
      end
      chk("t6_reached_payload", 64'(mon_q.size() >= 3), 64'd1);
    end
    reset = 1'b1;
    in_wr = '0;
    for (int q = 0; q < 8; q++) pend[q].delete();
    @(posedge clk); #1;
    chk("t6_rst_out_wr", 64'(out_wr), 64'd0);
    chk("t6_rst_in_rdy", 64'(in_rdy), 64'hFF);
    chk("t6_rst_rr_ptr", 64'(dut.rr_ptr), 64'd0);
    chk("t6_rst_cq", 64'(cur_queue), 64'd0);
    reset = 1'b0;
    mon_q.delete();
    exp_q.delete();
    add_pkt(6, 4, 1, 8'hF6);
    run(15);
    check_log("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
